// File: rtl/ccc_reset_pkg.sv
// Shared types and constants for the CCC lock-qualified reset sequencer.
package ccc_reset_pkg;

  typedef enum logic [2:0] {
    ST_RESET       = 3'd0,
    ST_WAIT_LOCK   = 3'd1,
    ST_LOCK_FILTER = 3'd2,
    ST_FABRIC_HOLD = 3'd3,
    ST_CORE_HOLD   = 3'd4,
    ST_RUN         = 3'd5,
    ST_SW_RESET    = 3'd6
  } state_t;

  localparam int LOCK_LOSS_MAX = 255;

  // Fabric peripherals stay in reset until lock has been qualified and held.
  function automatic logic fabricInReset(input state_t s);
    return (s == ST_RESET) || (s == ST_WAIT_LOCK) ||
           (s == ST_LOCK_FILTER) || (s == ST_FABRIC_HOLD);
  endfunction

  // Losing lock once the fabric hold has started is a counted event.
  function automatic logic lockLossCounted(input state_t s);
    return (s == ST_FABRIC_HOLD) || (s == ST_CORE_HOLD) ||
           (s == ST_RUN) || (s == ST_SW_RESET);
  endfunction

endpackage

// File: rtl/ccc_sync_cell.sv
// Multi-flop synchronizer bringing an asynchronous level into the GL0 domain.
module ccc_sync_cell #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_sync
);

  logic [SYNC_STAGES-1:0] r_chain;

  // Shift the raw input through the chain; the oldest stage is the safe copy.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/ccc_lock_reset_seq.sv
// Reset sequencer: releases fabric then core reset once PLL lock is stable,
// falls back to waiting for lock on any loss, and offers a core-only pulse.
module ccc_lock_reset_seq
  import ccc_reset_pkg::*;
#(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int FABRIC_HOLD_CYCLES = 16,
  parameter int CORE_DELAY_CYCLES  = 64,
  parameter int SW_RESET_CYCLES    = 32,
  parameter int CNT_W              = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_pll_lock,
  input  logic       i_init_done,
  input  logic       i_sw_reset_req,
  output logic       o_fabric_reset,
  output logic       o_core_reset,
  output logic       o_ready,
  output logic [7:0] o_lock_loss_cnt,
  output logic [2:0] o_state
);

  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] FABRIC_LAST = CNT_W'(FABRIC_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CORE_LAST   = CNT_W'(CORE_DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] SW_LAST     = CNT_W'(SW_RESET_CYCLES - 1);
  localparam logic [7:0]       LOSS_SAT    = 8'(LOCK_LOSS_MAX);

  logic             w_lockS;
  logic             w_initS;
  state_t           r_state;
  state_t           w_next;
  logic             w_lossEvent;
  logic [CNT_W-1:0] r_timer;
  logic [7:0]       r_lossCnt;
  logic             r_fabricReset;
  logic             r_coreReset;
  logic             r_ready;

  ccc_sync_cell #(.SYNC_STAGES(SYNC_STAGES)) u_lockSync (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_async (i_pll_lock),
    .o_sync  (w_lockS)
  );

  ccc_sync_cell #(.SYNC_STAGES(SYNC_STAGES)) u_initSync (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_async (i_init_done),
    .o_sync  (w_initS)
  );

  // Next-state logic; lock loss is checked first so it beats timer expiry
  // and software requests landing in the same cycle.
  always_comb begin
    w_next      = r_state;
    w_lossEvent = 1'b0;
    case (r_state)
      ST_RESET: begin
        w_next = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (w_lockS && w_initS) begin
          w_next = ST_LOCK_FILTER;
        end
      end
      ST_LOCK_FILTER: begin
        if (!w_lockS) begin
          w_next = ST_WAIT_LOCK;
        end else if (r_timer == LOCK_LAST) begin
          w_next = ST_FABRIC_HOLD;
        end
      end
      ST_FABRIC_HOLD: begin
        if (!w_lockS) begin
          w_next = ST_WAIT_LOCK;
        end else if (r_timer == FABRIC_LAST) begin
          w_next = ST_CORE_HOLD;
        end
      end
      ST_CORE_HOLD: begin
        if (!w_lockS) begin
          w_next = ST_WAIT_LOCK;
        end else if (r_timer == CORE_LAST) begin
          w_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!w_lockS) begin
          w_next = ST_WAIT_LOCK;
        end else if (i_sw_reset_req) begin
          w_next = ST_SW_RESET;
        end
      end
      ST_SW_RESET: begin
        if (!w_lockS) begin
          w_next = ST_WAIT_LOCK;
        end else if (r_timer == SW_LAST) begin
          w_next = ST_RUN;
        end
      end
      default: begin
        w_next = ST_RESET;
      end
    endcase
    if (!w_lockS && lockLossCounted(r_state)) begin
      w_lossEvent = 1'b1;
    end
  end

  // State register; the timer restarts from zero on every state change.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_RESET;
      r_timer <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) begin
        r_timer <= '0;
      end else begin
        r_timer <= r_timer + CNT_W'(1);
      end
    end
  end

  // Saturating count of lock losses after qualification.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_lossCnt <= '0;
    end else if (w_lossEvent && (r_lossCnt != LOSS_SAT)) begin
      r_lossCnt <= r_lossCnt + 8'd1;
    end
  end

  // Outputs decoded from next-state so they move on the same edge as STATE.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_fabricReset <= 1'b1;
      r_coreReset   <= 1'b1;
      r_ready       <= 1'b0;
    end else begin
      r_fabricReset <= fabricInReset(w_next);
      r_coreReset   <= (w_next != ST_RUN);
      r_ready       <= (w_next == ST_RUN);
    end
  end

  assign o_fabric_reset  = r_fabricReset;
  assign o_core_reset    = r_coreReset;
  assign o_ready         = r_ready;
  assign o_lock_loss_cnt = r_lossCnt;
  assign o_state         = r_state;

endmodule

// File: tb/tb_ccc_lock_reset_seq.sv
// Bench for ccc_lock_reset_seq: directed scenarios plus a randomized run, all
// compared every cycle against a phase/age model of the reset sequence.
module tb_ccc_lock_reset_seq;

  localparam int SYNC = 2;
  localparam int L    = 8;
  localparam int H    = 4;
  localparam int D    = 6;
  localparam int S    = 3;

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic       pllLock  = 1'b0;
  logic       initDone = 1'b0;
  logic       swReq    = 1'b0;
  logic       fabricReset;
  logic       coreReset;
  logic       ready;
  logic [7:0] lossCnt;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;
  int printed = 0;

  // Model: raw input history plus "age since lock qualification began".
  bit lockHist [SYNC];
  bit initHist [SYNC];
  bit mStarted = 1'b0;
  int mAge     = -1;
  int mSwLeft  = 0;
  int mLosses  = 0;
  bit mLockS;
  bit mInitS;

  ccc_lock_reset_seq #(
    .SYNC_STAGES        (SYNC),
    .LOCK_STABLE_CYCLES (L),
    .FABRIC_HOLD_CYCLES (H),
    .CORE_DELAY_CYCLES  (D),
    .SW_RESET_CYCLES    (S),
    .CNT_W              (16)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_pll_lock      (pllLock),
    .i_init_done     (initDone),
    .i_sw_reset_req  (swReq),
    .o_fabric_reset  (fabricReset),
    .o_core_reset    (coreReset),
    .o_ready         (ready),
    .o_lock_loss_cnt (lossCnt),
    .o_state         (state)
  );

  always #5 clk = ~clk;

  // Expected state number derived from where the sequence is in time.
  function automatic int modelState();
    if (!mStarted) return 0;
    if (mAge < 0) return 1;
    if (mAge < L) return 2;
    if (mAge < L + H) return 3;
    if (mAge < L + H + D) return 4;
    if (mSwLeft > 0) return 6;
    return 5;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      if (printed < 60) begin
        printed++;
        $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
    end
  endtask

  task automatic applyStimulus(input bit lock, input bit init, input bit sw);
    pllLock  = lock;
    initDone = init;
    swReq    = sw;
  endtask

  task automatic stepCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic waitModelState(input int target, input int budget);
    int n;
    n = 0;
    while (modelState() != target && n < budget) begin
      stepCycles(1);
      n++;
    end
    if (modelState() != target) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_state: got %0d, expected %0d within %0d cycles", modelState(), target, budget);
    end
  endtask

  // Reference model advance: sees inputs as they were SYNC edges ago.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mStarted = 1'b0;
      mAge     = -1;
      mSwLeft  = 0;
      mLosses  = 0;
      for (int i = 0; i < SYNC; i++) begin
        lockHist[i] = 1'b0;
        initHist[i] = 1'b0;
      end
    end else begin
      mLockS = lockHist[SYNC-1];
      mInitS = initHist[SYNC-1];
      for (int i = SYNC - 1; i > 0; i--) begin
        lockHist[i] = lockHist[i-1];
        initHist[i] = initHist[i-1];
      end
      lockHist[0] = pllLock;
      initHist[0] = initDone;
      if (!mStarted) begin
        mStarted = 1'b1;
      end else if (mAge < 0) begin
        if (mLockS && mInitS) mAge = 0;
      end else if (!mLockS) begin
        if (mAge >= L && mLosses < 255) mLosses++;
        mAge    = -1;
        mSwLeft = 0;
      end else if (mAge >= L + H + D) begin
        if (mSwLeft > 0) mSwLeft--;
        else if (swReq) mSwLeft = S;
      end else begin
        mAge++;
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    checkOutput("state", 32'(state), modelState());
    checkOutput("fabric_reset", 32'(fabricReset), (modelState() <= 3) ? 1 : 0);
    checkOutput("core_reset", 32'(coreReset), (modelState() != 5) ? 1 : 0);
    checkOutput("ready", 32'(ready), (modelState() == 5) ? 1 : 0);
    checkOutput("lock_loss_cnt", 32'(lossCnt), mLosses);
  end

  initial begin
    bit lockR;
    bit initR;
    bit swR;

    // Reset values with lock and init already high.
    applyStimulus(1'b1, 1'b1, 1'b0);
    stepCycles(3);
    checkOutput("rst_fabric", 32'(fabricReset), 1);
    checkOutput("rst_core", 32'(coreReset), 1);
    checkOutput("rst_ready", 32'(ready), 0);
    checkOutput("rst_cnt", 32'(lossCnt), 0);
    checkOutput("rst_state", 32'(state), 0);

    // Clean bring-up: filter entry 3 edges after release, fabric +12, core +18.
    rst = 1'b0;
    stepCycles(2);
    checkOutput("up_wait", 32'(state), 1);
    stepCycles(1);
    checkOutput("up_filter", 32'(state), 2);
    stepCycles(11);
    checkOutput("up_fabric_held", 32'(fabricReset), 1);
    stepCycles(1);
    checkOutput("up_fabric_fall", 32'(fabricReset), 0);
    checkOutput("up_core_held", 32'(coreReset), 1);
    checkOutput("up_corehold", 32'(state), 4);
    stepCycles(5);
    checkOutput("up_core_still", 32'(coreReset), 1);
    stepCycles(1);
    checkOutput("up_core_fall", 32'(coreReset), 0);
    checkOutput("up_ready", 32'(ready), 1);
    checkOutput("up_run", 32'(state), 5);
    checkOutput("up_cnt", 32'(lossCnt), 0);

    // Software core reset pulse of exactly 3 cycles.
    applyStimulus(1'b1, 1'b1, 1'b1);
    stepCycles(1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("sw_state", 32'(state), 6);
    checkOutput("sw_core", 32'(coreReset), 1);
    checkOutput("sw_ready", 32'(ready), 0);
    checkOutput("sw_fabric", 32'(fabricReset), 0);
    stepCycles(2);
    checkOutput("sw_core_still", 32'(coreReset), 1);
    stepCycles(1);
    checkOutput("sw_core_release", 32'(coreReset), 0);
    checkOutput("sw_ready_back", 32'(ready), 1);

    // Lock loss and software request in the same cycle.
    applyStimulus(1'b0, 1'b1, 1'b0);
    stepCycles(2);
    applyStimulus(1'b0, 1'b1, 1'b1);
    stepCycles(1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("both_state", 32'(state), 1);
    checkOutput("both_cnt", 32'(lossCnt), 1);
    checkOutput("both_fabric", 32'(fabricReset), 1);
    checkOutput("both_core", 32'(coreReset), 1);

    // Request during core hold is dropped, not queued.
    applyStimulus(1'b1, 1'b1, 1'b0);
    waitModelState(4, 40);
    applyStimulus(1'b1, 1'b1, 1'b1);
    stepCycles(1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("corehold_sw", 32'(state), 4);
    waitModelState(5, 20);
    stepCycles(1);
    checkOutput("corehold_noqueue", 32'(state), 5);

    // Lock glitch during the filter at timer 5 restarts qualification.
    applyStimulus(1'b0, 1'b1, 1'b0);
    waitModelState(1, 10);
    applyStimulus(1'b1, 1'b1, 1'b0);
    waitModelState(2, 10);
    stepCycles(3);
    applyStimulus(1'b0, 1'b1, 1'b0);
    stepCycles(1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    stepCycles(1);
    checkOutput("glitch_t5", 32'(state), 2);
    stepCycles(1);
    checkOutput("glitch_back", 32'(state), 1);
    checkOutput("glitch_cnt", 32'(lossCnt), 2);
    stepCycles(1);
    checkOutput("glitch_refilter", 32'(state), 2);

    // Asynchronous reset in the middle of core hold.
    waitModelState(4, 40);
    stepCycles(2);
    rst = 1'b1;
    #1;
    checkOutput("async_fabric", 32'(fabricReset), 1);
    checkOutput("async_core", 32'(coreReset), 1);
    checkOutput("async_ready", 32'(ready), 0);
    checkOutput("async_state", 32'(state), 0);
    checkOutput("async_cnt", 32'(lossCnt), 0);
    stepCycles(2);
    rst = 1'b0;

    // 300 lock losses from RUN; counter must stop at 255.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0);
      waitModelState(5, 60);
      applyStimulus(1'b0, 1'b1, 1'b0);
      stepCycles(3);
      checkOutput("loss_state", 32'(state), 1);
      checkOutput("loss_fabric", 32'(fabricReset), 1);
    end
    checkOutput("loss_saturated", 32'(lossCnt), 255);

    // Randomized run with short lock dropouts, init toggles and rare resets.
    lockR = 1'b1;
    initR = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      if (lockR) lockR = ($urandom_range(0, 59) != 0);
      else       lockR = ($urandom_range(0, 3) == 0);
      if (initR) initR = ($urandom_range(0, 199) != 0);
      else       initR = ($urandom_range(0, 9) == 0);
      swR = ($urandom_range(0, 7) == 0);
      applyStimulus(lockR, initR, swR);
      rst = ($urandom_range(0, 799) == 0);
      stepCycles(1);
    end
    rst = 1'b0;
    stepCycles(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ccc_lock_reset_seq.md
# ccc_lock_reset_seq

Reset sequencer that sits directly downstream of the subsystem fabric CCC. It runs on the CCC's GL0 output and consumes the asynchronous PLL LOCK and system-controller INIT_DONE signals. It releases fabric reset and then CoreRISCV reset in a fixed, lock-qualified order. It re-enters reset on any loss of lock and supports a software-requested core-only reset.

## Interface
Parameters:
- SYNC_STAGES, 2: synchronizer depth for PLL_LOCK and INIT_DONE; legal range 2..4.
- LOCK_STABLE_CYCLES, 1024: cycles lock must stay continuously high before any release.
- FABRIC_HOLD_CYCLES, 16: extra cycles fabric reset is held after lock qualification.
- CORE_DELAY_CYCLES, 64: cycles between fabric release and core release.
- SW_RESET_CYCLES, 32: core reset pulse length for a software request.
- CNT_W, 16: timer width; must hold max(all cycle parameters).

Ports:
- CLK  in  1  GL0 from CCC; the only clock.
- RESET  in  1  asynchronous, active-high; asserts async, deassertion is synchronous to CLK.
- PLL_LOCK  in  1  CCC LOCK; asynchronous to CLK.
- INIT_DONE  in  1  system-controller init done; asynchronous.
- SW_RESET_REQ  in  1  synchronous single-cycle core reset request.
- FABRIC_RESET  out  1  active-high reset to fabric peripherals and AXI interconnect.
- CORE_RESET  out  1  active-high reset to CoreRISCV.
- READY  out  1  high only in RUN.
- LOCK_LOSS_CNT  out  8  saturating count of post-qualification lock losses.
- STATE  out  3  current state encoding, for debug.

## Operation
- lock_s and init_s are PLL_LOCK and INIT_DONE after SYNC_STAGES flops, reset to 0.
- States and encodings: ST_RESET 0, ST_WAIT_LOCK 1, ST_LOCK_FILTER 2, ST_FABRIC_HOLD 3, ST_CORE_HOLD 4, ST_RUN 5, ST_SW_RESET 6. Encodings 7 and above are illegal and go to ST_RESET.
- RESET asserted: state=ST_RESET, FABRIC_RESET=1, CORE_RESET=1, READY=0, LOCK_LOSS_CNT=0, timer=0, sync flops=0.
- ST_RESET goes to ST_WAIT_LOCK unconditionally on the next edge.
- ST_WAIT_LOCK: when lock_s and init_s are both high, go to ST_LOCK_FILTER with timer=0.
- ST_LOCK_FILTER:
  - lock_s low: return to ST_WAIT_LOCK; LOCK_LOSS_CNT is not counted.
  - timer==LOCK_STABLE_CYCLES-1: go to ST_FABRIC_HOLD.
- ST_FABRIC_HOLD: at timer==FABRIC_HOLD_CYCLES-1, go to ST_CORE_HOLD.
- ST_CORE_HOLD: at timer==CORE_DELAY_CYCLES-1, go to ST_RUN.
- ST_RUN: when SW_RESET_REQ is high, go to ST_SW_RESET.
- ST_SW_RESET: at timer==SW_RESET_CYCLES-1, return to ST_RUN.
- Timer behaviour: cleared on every state change, incremented otherwise; each timed state lasts exactly its parameter in cycles.
- Lock loss:
  - Applies when lock_s is low in ST_FABRIC_HOLD, ST_CORE_HOLD, ST_RUN or ST_SW_RESET.
  - Next state is ST_WAIT_LOCK; LOCK_LOSS_CNT increments and saturates at 255.
  - Lock loss takes priority over SW_RESET_REQ and over timer expiry in the same cycle.
- init_s falling after qualification is ignored; INIT_DONE is only sampled in ST_WAIT_LOCK.
- SW_RESET_REQ outside ST_RUN is ignored; no queuing.
- Outputs are registered and decoded from next-state, so they change on the same edge as STATE:
  - FABRIC_RESET=1 in ST_RESET, ST_WAIT_LOCK, ST_LOCK_FILTER, ST_FABRIC_HOLD.
  - CORE_RESET=1 in every state except ST_RUN.
  - READY = (state==ST_RUN).

## Timing
- Let E0 be the edge entering ST_LOCK_FILTER, with lock held throughout.
  - FABRIC_RESET falls at E0+LOCK_STABLE_CYCLES+FABRIC_HOLD_CYCLES.
  - CORE_RESET falls and READY rises CORE_DELAY_CYCLES later.
- Input latency: a PLL_LOCK edge is visible to the FSM after SYNC_STAGES edges.
- Lock loss in RUN: both resets assert and READY falls on the edge after lock_s goes low.
- SW request:
  - Sampled high in RUN at edge En: CORE_RESET=1 and READY=0 from En.
  - Released at En+SW_RESET_CYCLES.
  - FABRIC_RESET stays 0 throughout.
- RESET asserted mid-sequence: outputs go to their reset values asynchronously, within the same cycle, not on the next edge.

## Structure
- Package ccc_reset_pkg: state enum with the encodings above, and a LOCK_LOSS_MAX=255 constant.
- Sub-module ccc_sync_cell: parameterised SYNC_STAGES flop chain with async active-high reset to 0. Instantiated twice, for PLL_LOCK and INIT_DONE.

## Test plan
Test bench parameters: LOCK_STABLE_CYCLES=8, FABRIC_HOLD_CYCLES=4, CORE_DELAY_CYCLES=6, SW_RESET_CYCLES=3.
- Clean bring-up: lock and init high from RESET release -> FABRIC_RESET falls 12 cycles after ST_LOCK_FILTER entry; CORE_RESET falls and READY rises 6 cycles after that; LOCK_LOSS_CNT=0.
- Lock glitch in filter: lock low for 1 cycle at filter timer=5 -> back to ST_WAIT_LOCK; filter restarts from 0; LOCK_LOSS_CNT stays 0.
- Lock loss in RUN, repeated 300 times -> each loss asserts both resets the next cycle; LOCK_LOSS_CNT saturates at 255.
- SW_RESET_REQ pulse in RUN -> CORE_RESET high for exactly 3 cycles; FABRIC_RESET stays 0; READY returns after. A request raised during ST_CORE_HOLD has no effect.
- SW_RESET_REQ and lock loss in the same cycle -> ST_WAIT_LOCK, LOCK_LOSS_CNT+1, FABRIC_RESET=1.
- RESET asserted mid ST_CORE_HOLD -> FABRIC_RESET=1, CORE_RESET=1, STATE=0 asynchronously, before the next CLK edge; LOCK_LOSS_CNT=0.
